// File: rtl/fetch_unit.sv
// fetch_unit: stage-1 instruction fetch. Owns the PC, issues credit-limited
// in-order imem requests and buffers responses in a small instruction FIFO.
package fetch_pkg;
  localparam int PC_MUX_SEL_WIDTH = 2;

  typedef enum logic [PC_MUX_SEL_WIDTH-1:0] {
    PC_MUX_PLUS_4 = 2'd0,
    PC_MUX_BRANCH = 2'd1,
    PC_MUX_J      = 2'd2
  } pc_mux_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_ent_t;
endpackage

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_2000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PC_MUX_SEL_WIDTH-1:0] pc_mux_sel,
  input  logic [31:0]                 branch_target,
  input  logic [31:0]                 jump_target,
  output logic                        imem_req_valid,
  input  logic                        imem_req_ready,
  output logic [31:0]                 imem_req_addr,
  input  logic                        imem_resp_valid,
  input  logic [31:0]                 imem_resp_data,
  output logic [31:0]                 instruction_1,
  output logic [31:0]                 pc_1
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W:0] DEPTH_C =
    (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL =
    CNT_W'(FIFO_DEPTH);

  logic              started_q;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  fetch_ent_t        fifo_q [FIFO_DEPTH];

  logic              redirect;
  logic [31:0]       target;
  logic [CNT_W:0]    credit_used;
  logic              credit_ok;
  logic              accept;
  logic              drop_resp;
  logic              push;
  logic              pop;
  fetch_ent_t        head;

  // Redirect decode and target select.
  always_comb begin
    redirect = (pc_mux_sel != PC_MUX_PLUS_4);
    target   = branch_target;
    unique case (1'b1)
      (pc_mux_sel == PC_MUX_J): target = jump_target;
      default:                  target = branch_target;
    endcase
  end

  // Request issue: every in-flight word must own a FIFO slot.
  always_comb begin
    credit_used    = {1'b0, cnt_q} + {1'b0, out_q};
    credit_ok      = (credit_used < DEPTH_C);
    imem_req_valid = started_q && !redirect && credit_ok;
    imem_req_addr  = fetch_pc_q;
    accept         = imem_req_valid && imem_req_ready;
  end

  // Response routing: stale or redirect-cycle words are discarded.
  always_comb begin
    drop_resp = imem_resp_valid && (redirect || (drop_q != '0));
    push      = imem_resp_valid && !drop_resp;
    pop       = (cnt_q != '0);
  end

  // Head of FIFO goes straight out; empty FIFO shows a bubble.
  always_comb begin
    head          = fifo_q[rd_ptr_q];
    instruction_1 = 32'b0;
    pc_1          = 32'b0;
    if (pop) begin
      instruction_1 = head.insn;
      pc_1          = head.pc;
    end
  end

  // PC bookkeeping: fetch address and tag of the next pushed word.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (redirect) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)   resp_pc_d  = resp_pc_q + 32'd4;
    end
  end

  // Counters: outstanding, stale-drop and FIFO occupancy.
  always_comb begin
    out_d = out_q + CNT_W'(accept)
                  - CNT_W'(imem_resp_valid);
    drop_d = drop_q;
    if (redirect) begin
      drop_d = out_q - CNT_W'(imem_resp_valid);
    end else if (imem_resp_valid && drop_q != '0) begin
      drop_d = drop_q - CNT_W'(1);
    end
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    if (redirect) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q  <= 1'b0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      cnt_q      <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      started_q  <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are only observed through cnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{pc: resp_pc_q,
                            insn: imem_resp_data};
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && cnt_q == CNT_FULL));

  a_no_orphan_resp: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(imem_resp_valid && out_q == '0));

  a_addr_aligned: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_req_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: queue-based reference model of fetch_unit with an
// in-order imem of configurable latency, plus directed scenarios.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b1;
  logic [PC_MUX_SEL_WIDTH-1:0] pc_mux_sel = PC_MUX_PLUS_4;
  logic [31:0]                 branch_target = '0;
  logic [31:0]                 jump_target = '0;
  logic                        imem_req_valid;
  logic                        imem_req_ready = 1'b1;
  logic [31:0]                 imem_req_addr;
  logic                        imem_resp_valid = 1'b0;
  logic [31:0]                 imem_resp_data = '0;
  logic [31:0]                 instruction_1;
  logic [31:0]                 pc_1;

  fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_mux_sel      (pc_mux_sel),
    .branch_target   (branch_target),
    .jump_target     (jump_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instruction_1   (instruction_1),
    .pc_1            (pc_1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } flight_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } word_t;

  flight_t     infl[$];
  word_t       mfifo[$];
  logic [31:0] m_pc = 32'h2000;
  bit          m_started = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          saw_stall = 0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    infl.delete();
    mfifo.delete();
    m_pc = 32'h2000;
    m_started = 0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
  endtask

  // Reference model and per-cycle compare.
  initial begin : model
    logic [PC_MUX_SEL_WIDTH-1:0] s_sel;
    logic [31:0] s_bt, s_jt;
    bit s_rdy, s_rv, s_ev, red;
    flight_t h;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h2000);
        chk("rst_insn", instruction_1, 32'd0);
        chk("rst_pc", pc_1, 32'd0);
        continue;
      end
      red = (pc_mux_sel != PC_MUX_PLUS_4);
      s_ev = m_started && !red && (mfifo.size() + infl.size() < 4);
      if (m_started && !red && !s_ev) saw_stall = 1;
      chk("req_valid", 32'(imem_req_valid), 32'(s_ev));
      chk("req_addr", imem_req_addr, m_pc);
      chk("insn", instruction_1,
          mfifo.size() > 0 ? mfifo[0].data : 32'd0);
      chk("pc", pc_1, mfifo.size() > 0 ? mfifo[0].pc : 32'd0);
      chk("credit_bound", 32'(mfifo.size() + infl.size() <= 4), 32'd1);
      s_sel = pc_mux_sel;
      s_bt  = branch_target;
      s_jt  = jump_target;
      s_rdy = imem_req_ready;
      s_rv  = imem_resp_valid;
      @(posedge clk);
      if (!rst_n) continue;
      if (mfifo.size() > 0) void'(mfifo.pop_front());
      if (s_rv && infl.size() > 0) begin
        h = infl.pop_front();
        if (!h.stale && !red)
          mfifo.push_back('{h.addr, mem_word(h.addr)});
      end
      if (red) begin
        mfifo.delete();
        foreach (infl[i]) infl[i].stale = 1;
        m_pc = (s_sel == PC_MUX_J) ? s_jt : s_bt;
      end else if (s_ev && s_rdy) begin
        infl.push_back('{m_pc, cyc + lat, 1'b0});
        m_pc = m_pc + 32'd4;
      end
      m_started = 1;
      cyc++;
      #1;
      imem_resp_valid = 1'b0;
      imem_resp_data = '0;
      if (infl.size() > 0 && infl[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data = mem_word(infl[0].addr);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_first(input logic [31:0] pc, input string nm);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (instruction_1 != 32'd0) begin
        got = 1;
        chk({nm, "_pc"}, pc_1, pc);
        chk({nm, "_insn"}, instruction_1, mem_word(pc));
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: no word within 40 cycles, want pc %h",
               nm, pc);
    end
  endtask

  task automatic redirect(input pc_mux_e sel, input logic [31:0] tgt);
    pc_mux_sel = sel;
    if (sel == PC_MUX_J) jump_target = tgt;
    else branch_target = tgt;
    cycles(1);
    pc_mux_sel = PC_MUX_PLUS_4;
  endtask

  initial begin : stim
    logic [31:0] a0;
    int n;
    #2 rst_n = 1'b0;
    cycles(3);
    chk("reset_insn", instruction_1, 32'd0);
    chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
    rst_n = 1'b1;

    // 1: latency 1, sequential stream from RESET_PC
    cycles(3);
    chk("t1_first_insn", instruction_1, 32'hDEAD_2000);
    chk("t1_first_pc", pc_1, 32'h0000_2000);
    cycles(1);
    chk("t1_second_insn", instruction_1, 32'hDEAD_2004);
    chk("t1_second_pc", pc_1, 32'h0000_2004);
    cycles(10);

    // 2: latency 3, credit limit throttles issue
    lat = 3;
    saw_stall = 0;
    cycles(30);
    chk("t2_credit_stall", 32'(saw_stall), 32'd1);

    // 3: branch with at least two requests in flight
    n = 0;
    while (infl.size() < 2 && n < 20) begin
      cycles(1);
      n++;
    end
    chk("t3_inflight_ge2", 32'(infl.size() >= 2), 32'd1);
    redirect(PC_MUX_BRANCH, 32'h0000_2100);
    wait_first(32'h0000_2100, "t3");
    cycles(6);

    // 4: jump in the same cycle a response arrives
    n = 0;
    while (!imem_resp_valid && n < 20) begin
      cycles(1);
      n++;
    end
    chk("t4_resp_same_cycle", 32'(imem_resp_valid), 32'd1);
    redirect(PC_MUX_J, 32'h0000_2400);
    wait_first(32'h0000_2400, "t4");
    cycles(6);

    // back-to-back redirects: last target wins
    redirect(PC_MUX_BRANCH, 32'h0000_2800);
    redirect(PC_MUX_J, 32'h0000_2C00);
    wait_first(32'h0000_2C00, "b2b");
    cycles(6);

    // 5: imem stalls for 5 cycles at latency 1
    lat = 1;
    cycles(10);
    imem_req_ready = 1'b0;
    a0 = imem_req_addr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_addr_stable", imem_req_addr, a0);
    end
    chk("t5_bubble", instruction_1, 32'd0);
    cycles(1);
    imem_req_ready = 1'b1;
    wait_first(a0, "t5_resume");
    cycles(8);

    // 6: mid-stream reset
    rst_n = 1'b0;
    #1;
    chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t6_insn", instruction_1, 32'd0);
    chk("t6_pc", pc_1, 32'd0);
    chk("t6_addr", imem_req_addr, 32'h0000_2000);
    cycles(2);
    rst_n = 1'b1;
    wait_first(32'h0000_2000, "t6_restart");
    cycles(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
